// File: rtl/seg_share_arbiter_pkg.sv
// Shared definitions for the display-sharing arbiter: FSM encodings and word sizes.
package seg_share_arbiter_pkg;

  localparam int SEG_WORD_W = 16;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last,
// wrapping, with i_last itself considered last.
module seg_share_arbiter_rr_pick
  import seg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_found,
  output logic [IDX_W-1:0] o_winner
);

  // Scan positions last+1 .. last+N_REQ (mod N_REQ); the first hit wins.
  always_comb begin
    o_found  = 1'b0;
    o_winner = i_last;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!o_found && i_req[j] && (j == ((int'(i_last) + k) % N_REQ))) begin
          o_found  = 1'b1;
          o_winner = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin time-sharing of the seven-segment display between N_REQ producers,
// with a minimum on-screen hold before ownership may move to another producer.
//
//  state | meaning
//  IDLE  | nobody owns the display; data_out frozen at last shown word
//  HOLD  | owner granted, hold counter running; others may not preempt
//  OPEN  | hold served; any other requester takes over on the next edge
module seg_share_arbiter
  import seg_share_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int HOLD   = 16,
  parameter int HOLD_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [SEG_WORD_W*N_REQ-1:0] i_data_in,
  output logic [N_REQ-1:0]            o_grant,
  output logic [IDX_W-1:0]            o_owner,
  output logic                        o_busy,
  output logic [SEG_WORD_W-1:0]       o_data_out
);

  seg_state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]      r_grant, w_grant_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [SEG_WORD_W-1:0] r_data_out, w_data_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt, w_cnt_nxt, w_cnt_inc;

  logic [N_REQ-1:0]      w_pick_req;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;
  logic [N_REQ-1:0]      w_win_onehot;
  logic [SEG_WORD_W-1:0] w_owner_word, w_win_word;
  logic                  w_owner_req;

  // In OPEN the current owner is masked so only a different requester can switch.
  assign w_pick_req  = (r_state == ST_OPEN) ? (i_req & ~r_grant) : i_req;
  assign w_owner_req = |(i_req & r_grant);
  assign w_cnt_inc   = (r_hold_cnt >= HOLD_W'(HOLD)) ? HOLD_W'(HOLD) : r_hold_cnt + 1'b1;

  seg_share_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (w_pick_req),
    .i_last   (r_owner),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Word selection for the current owner and the prospective winner.
  always_comb begin
    w_owner_word = '0;
    w_win_word   = '0;
    w_win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == IDX_W'(i)) w_owner_word = i_data_in[SEG_WORD_W*i +: SEG_WORD_W];
      if (w_winner == IDX_W'(i)) begin
        w_win_word      = i_data_in[SEG_WORD_W*i +: SEG_WORD_W];
        w_win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state, grant and display-word decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_data_out;
    w_cnt_nxt   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_grant_nxt = w_win_onehot;
          w_owner_nxt = w_winner;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = HOLD_W'(1);
        end
      end
      ST_HOLD: begin
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_data_nxt = w_owner_word;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_inc == HOLD_W'(HOLD)) w_state_nxt = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_grant_nxt = w_win_onehot;
          w_owner_nxt = w_winner;
          w_data_nxt  = w_win_word;
          w_cnt_nxt   = HOLD_W'(1);
        end else if (w_owner_req) begin
          w_data_nxt = w_owner_word;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset points the rotation so requester 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= IDX_W'(N_REQ - 1);
      r_busy     <= 1'b0;
      r_data_out <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_busy     <= w_busy_nxt;
      r_data_out <= w_data_nxt;
      r_hold_cnt <= w_cnt_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_owner    = r_owner;
  assign o_busy     = r_busy;
  assign o_data_out = r_data_out;

endmodule
